// File: rtl/loom_axi4_pkg.sv
// rtl/loom_axi4_pkg.sv - shared AXI4 encodings and helpers for Loom AXI masters
package loom_axi4_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
    localparam logic [2:0] PROT_DEFAULT  = 3'b000;

    // AxSIZE encoding for a full-width beat of data_width bits
    function automatic logic [2:0] size_from_width(input int unsigned data_width);
        int unsigned bytes;
        logic [2:0]  sz;
        bytes = data_width / 8;
        sz    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((32'd1 << i) == bytes) begin
                sz = i[2:0];
            end
        end
        return sz;
    endfunction

endpackage

// File: rtl/loom_axi4_burst_mst.sv
// rtl/loom_axi4_burst_mst.sv - single-outstanding AXI4 INCR burst master for Loom agents
module loom_axi4_burst_mst
    import loom_axi4_pkg::*;
#(
    parameter int unsigned         ID_WIDTH   = 4,
    parameter int unsigned         DATA_WIDTH = 128,
    parameter logic [ID_WIDTH-1:0] AXI_ID     = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_write_i,
    input  logic [63:0]             cmd_addr_i,
    input  logic [7:0]              cmd_len_i,

    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,

    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [1:0]              rresp_o,
    output logic                    rlast_o,
    output logic                    rvalid_o,
    input  logic                    rready_i,

    output logic                    done_valid_o,
    input  logic                    done_ready_i,
    output logic [1:0]              done_resp_o,
    output logic                    busy_o,

    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [63:0]             m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awlock,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,

    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,

    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,

    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [63:0]             m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arlock,
    output logic [3:0]              m_axi_arcache,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,

    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam logic [2:0] AXI_SIZE = size_from_width(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_W,
        S_DATA_W,
        S_RESP_W,
        S_ADDR_R,
        S_DATA_R,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [1:0]  resp_q, resp_d;
    logic [8:0]  cnt_inc;
    logic [8:0]  beats_exp;
    logic        unused_ids;

    // Only one transaction is ever in flight, so returned IDs carry no information
    assign unused_ids = ^{m_axi_bid, m_axi_rid};

    assign cnt_inc   = (cnt_q == 9'h1FF) ? cnt_q : cnt_q + 9'd1;
    assign beats_exp = {1'b0, len_q} + 9'd1;

    assign m_axi_awid    = AXI_ID;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = AXI_SIZE;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = CACHE_DEFAULT;
    assign m_axi_awprot  = PROT_DEFAULT;

    assign m_axi_arid    = AXI_ID;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = AXI_SIZE;
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = CACHE_DEFAULT;
    assign m_axi_arprot  = PROT_DEFAULT;

    assign m_axi_wdata = wdata_i;
    assign m_axi_wstrb = wstrb_i;
    assign rdata_o     = m_axi_rdata;
    assign rresp_o     = m_axi_rresp;
    assign rlast_o     = m_axi_rlast;
    assign done_resp_o = resp_q;
    assign busy_o      = (state_q != S_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            resp_q  <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        resp_d        = resp_q;
        cmd_ready_o   = 1'b0;
        wready_o      = 1'b0;
        rvalid_o      = 1'b0;
        done_valid_o  = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready_o = ~rst_i;
                if (cmd_valid_i && cmd_ready_o) begin
                    addr_d  = cmd_addr_i;
                    len_d   = cmd_len_i;
                    cnt_d   = '0;
                    resp_d  = RESP_OKAY;
                    state_d = cmd_write_i ? S_ADDR_W : S_ADDR_R;
                end
            end
            S_ADDR_W: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) begin
                    state_d = S_DATA_W;
                end
            end
            S_DATA_W: begin
                m_axi_wvalid = wvalid_i;
                wready_o     = m_axi_wready;
                m_axi_wlast  = (cnt_q == {1'b0, len_q});
                if (wvalid_i && m_axi_wready) begin
                    cnt_d = cnt_inc;
                    if (m_axi_wlast) begin
                        state_d = S_RESP_W;
                    end
                end
            end
            S_RESP_W: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    resp_d  = m_axi_bresp;
                    state_d = S_DONE;
                end
            end
            S_ADDR_R: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_d = S_DATA_R;
                end
            end
            S_DATA_R: begin
                m_axi_rready = rready_i;
                rvalid_o     = m_axi_rvalid;
                if (m_axi_rvalid && rready_i) begin
                    cnt_d  = cnt_inc;
                    resp_d = (m_axi_rresp > resp_q) ? m_axi_rresp : resp_q;
                    if (m_axi_rlast) begin
                        // A short or long burst is reported as a slave error regardless of beat resps
                        if (cnt_inc != beats_exp) begin
                            resp_d = RESP_SLVERR;
                        end
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done_valid_o = 1'b1;
                if (done_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_loom_axi4_burst_mst.sv
// tb/tb_loom_axi4_burst_mst.sv - directed bench for loom_axi4_burst_mst
module tb_loom_axi4_burst_mst;

    localparam int IDW = 4;
    localparam int DW  = 128;

    logic            clk_i, rst_i;
    logic            cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [63:0]     cmd_addr_i;
    logic [7:0]      cmd_len_i;
    logic [DW-1:0]   wdata_i;
    logic [DW/8-1:0] wstrb_i;
    logic            wvalid_i, wready_o;
    logic [DW-1:0]   rdata_o;
    logic [1:0]      rresp_o;
    logic            rlast_o, rvalid_o, rready_i;
    logic            done_valid_o, done_ready_i;
    logic [1:0]      done_resp_o;
    logic            busy_o;
    logic [IDW-1:0]  m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
    logic [63:0]     m_axi_awaddr, m_axi_araddr;
    logic [7:0]      m_axi_awlen, m_axi_arlen;
    logic [2:0]      m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
    logic [1:0]      m_axi_awburst, m_axi_arburst;
    logic            m_axi_awlock, m_axi_arlock;
    logic [3:0]      m_axi_awcache, m_axi_arcache;
    logic            m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
    logic [DW-1:0]   m_axi_wdata, m_axi_rdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic            m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]      m_axi_bresp, m_axi_rresp;
    logic            m_axi_bvalid, m_axi_bready;
    logic            m_axi_rlast, m_axi_rvalid, m_axi_rready;

    loom_axi4_burst_mst #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .AXI_ID(4'h0)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
        .done_valid_o(done_valid_o), .done_ready_i(done_ready_i), .done_resp_o(done_resp_o), .busy_o(busy_o),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] rec_data [0:31];
    logic [1:0]    rec_resp [0:31];
    logic          rec_last [0:31];
    logic [1:0]    rd_resp_tab [0:31];
    int            rec_n, rec_last_cnt, rec_acc_iter, rec_done_iter;
    logic [63:0]   rec_addr;
    logic [7:0]    rec_len;
    logic [2:0]    rec_size;
    logic [1:0]    rec_burst;
    logic [3:0]    rec_cache;
    logic [1:0]    rec_done_resp;
    logic          rec_busy;
    bit            rec_unstable, rec_timeout;

    function automatic logic [DW-1:0] rd_pat(input int i);
        logic [31:0] w;
        w = 32'hA500_0000 + 32'(i);
        return {w, ~w, w ^ 32'h5A5A_5A5A, w + 32'd7};
    endfunction

    function automatic logic [DW-1:0] wr_pat(input int i);
        logic [31:0] w;
        w = 32'h3C00_0100 + 32'(i);
        return {w + 32'd1, w, ~w, w ^ 32'hFFFF_0000};
    endfunction

    task automatic clear_rec();
        rec_n = 0; rec_last_cnt = 0; rec_acc_iter = -1; rec_done_iter = -1;
        rec_unstable = 0; rec_timeout = 0; rec_done_resp = 2'bxx; rec_busy = 1'bx;
    endtask

    task automatic run_read(input logic [63:0] addr, input logic [7:0] len, input int nbeats, input bit stall);
        int it = 0;
        int phase = 0;
        int idx = 0;
        clear_rec();
        while (phase != 3) begin
            @(posedge clk_i); #1;
            cmd_valid_i = (phase == 0); cmd_write_i = 1'b0; cmd_addr_i = addr; cmd_len_i = len;
            m_axi_arready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            rready_i      = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (phase == 2 && idx < nbeats) begin
                m_axi_rvalid = 1'b1; m_axi_rdata = rd_pat(idx);
                m_axi_rresp = rd_resp_tab[idx]; m_axi_rlast = (idx == nbeats - 1);
            end else begin
                m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
            end
            done_ready_i = 1'b1;
            #1;
            if (m_axi_arvalid && (m_axi_araddr !== addr || m_axi_arlen !== len)) rec_unstable = 1;
            if (phase == 0 && cmd_ready_o) begin
                phase = 1; rec_acc_iter = it;
            end else if (phase == 1 && m_axi_arvalid && m_axi_arready) begin
                rec_addr = m_axi_araddr; rec_len = m_axi_arlen; rec_size = m_axi_arsize;
                rec_burst = m_axi_arburst; rec_cache = m_axi_arcache; phase = 2;
            end else if (phase == 2 && rvalid_o && rready_i && rec_n < 32) begin
                rec_data[rec_n] = rdata_o; rec_resp[rec_n] = rresp_o; rec_last[rec_n] = rlast_o;
                if (rlast_o) rec_last_cnt++;
                rec_n++; idx++;
            end
            if (done_valid_o && rec_done_iter < 0) rec_done_iter = it;
            if (done_valid_o && done_ready_i) begin
                rec_done_resp = done_resp_o; rec_busy = busy_o; phase = 3;
            end
            it++;
            if (it > 2000) begin rec_timeout = 1; phase = 3; end
        end
        cmd_valid_i = 1'b0;
    endtask

    task automatic run_write(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] bresp,
                             input bit stall, input int abort_beat);
        int it = 0;
        int phase = 0;
        int src = 0;
        bit b_pend = 0;
        bit w_hs = 0;
        clear_rec();
        wvalid_i = 1'b0;
        while (phase != 3) begin
            @(posedge clk_i); #1;
            if (w_hs) begin src++; wvalid_i = 1'b0; w_hs = 0; end
            cmd_valid_i = (phase == 0); cmd_write_i = 1'b1; cmd_addr_i = addr; cmd_len_i = len;
            m_axi_awready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            m_axi_wready  = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (src <= int'(len) && !wvalid_i) wvalid_i = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            wdata_i = wr_pat(src); wstrb_i = '1;
            m_axi_bvalid = b_pend; m_axi_bresp = bresp;
            done_ready_i = 1'b1;
            if (abort_beat >= 0 && phase == 2 && rec_n == abort_beat) begin
                rst_i = 1'b1;
                #1;
                phase = 3;
            end else begin
                #1;
                if (m_axi_awvalid && (m_axi_awaddr !== addr || m_axi_awlen !== len)) rec_unstable = 1;
                if (m_axi_bvalid && m_axi_bready) b_pend = 0;
                if (phase == 0 && cmd_ready_o) begin
                    phase = 1; rec_acc_iter = it;
                end else if (phase == 1 && m_axi_awvalid && m_axi_awready) begin
                    rec_addr = m_axi_awaddr; rec_len = m_axi_awlen; rec_size = m_axi_awsize;
                    rec_burst = m_axi_awburst; rec_cache = m_axi_awcache; phase = 2;
                end else if (phase == 2 && m_axi_wvalid && m_axi_wready && rec_n < 32) begin
                    rec_data[rec_n] = m_axi_wdata; rec_last[rec_n] = m_axi_wlast;
                    if (m_axi_wlast) begin rec_last_cnt++; b_pend = 1; end
                    rec_n++; w_hs = 1;
                end
                if (done_valid_o && rec_done_iter < 0) rec_done_iter = it;
                if (done_valid_o && done_ready_i) begin
                    rec_done_resp = done_resp_o; rec_busy = busy_o; phase = 3;
                end
            end
            it++;
            if (it > 2000) begin rec_timeout = 1; phase = 3; end
        end
        cmd_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 64'h40; cmd_len_i = 8'd2;
        wvalid_i = 1'b1; wdata_i = '0; wstrb_i = '0; rready_i = 1'b1; done_ready_i = 1'b0;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
        m_axi_bid = '0; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b1;
        m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b1;
        #3;
        total++;
        if (cmd_ready_o !== 1'b0) begin bad++; $display("FAIL reset_cmd_ready got=%b want=0", cmd_ready_o); end
        total++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rvalid_o, wready_o, done_valid_o} !== 8'h00) begin
            bad++; $display("FAIL reset_valids got=%b want=00000000",
                {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rvalid_o, wready_o, done_valid_o});
        end
        total++;
        if ({busy_o, done_resp_o} !== 3'b000) begin bad++; $display("FAIL reset_busy_resp got=%b want=000", {busy_o, done_resp_o}); end
        total++;
        if ({m_axi_awaddr, m_axi_awlen} !== 72'h0) begin bad++; $display("FAIL reset_aw_fields got=%h want=0", {m_axi_awaddr, m_axi_awlen}); end
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0; wvalid_i = 1'b0; m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0; done_ready_i = 1'b1;
        rst_i = 1'b0;
        #1;
        total++;
        if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL release_cmd_ready got=%b want=1", cmd_ready_o); end
    endtask

    task automatic test_read_basic();
        for (int k = 0; k < 32; k++) rd_resp_tab[k] = 2'b00;
        run_read(64'h0000_0000_0000_0200, 8'd3, 4, 1'b0);
        total++;
        if (rec_timeout !== 1'b0) begin bad++; $display("FAIL rd_basic_timeout got=1 want=0"); end
        total++;
        if ({rec_addr, rec_len} !== {64'h200, 8'd3}) begin bad++; $display("FAIL rd_basic_ar got=%h/%0d want=200/3", rec_addr, rec_len); end
        total++;
        if ({rec_size, rec_burst, rec_cache} !== {3'd4, 2'b01, 4'b0011}) begin
            bad++; $display("FAIL rd_basic_fixed got=%0d/%b/%b want=4/01/0011", rec_size, rec_burst, rec_cache);
        end
        total++;
        if (rec_n !== 4) begin bad++; $display("FAIL rd_basic_beats got=%0d want=4", rec_n); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (rec_data[k] !== rd_pat(k) || rec_last[k] !== (k == 3)) begin
                bad++; $display("FAIL rd_basic_beat%0d got=%h last=%b want=%h last=%b", k, rec_data[k], rec_last[k], rd_pat(k), (k == 3));
            end
        end
        total++;
        if ({rec_done_resp, rec_busy} !== 3'b001) begin bad++; $display("FAIL rd_basic_done got=%b busy=%b want=00 busy=1", rec_done_resp, rec_busy); end
        @(posedge clk_i); #1;
        total++;
        if ({busy_o, cmd_ready_o, done_valid_o} !== 3'b010) begin
            bad++; $display("FAIL rd_basic_idle got busy/ready/done=%b want=010", {busy_o, cmd_ready_o, done_valid_o});
        end
    endtask

    task automatic test_write_single();
        run_write(64'h1000, 8'd0, 2'b11, 1'b0, -1);
        total++;
        if (rec_timeout !== 1'b0) begin bad++; $display("FAIL wr_single_timeout got=1 want=0"); end
        total++;
        if ({rec_addr, rec_len, rec_size, rec_burst} !== {64'h1000, 8'd0, 3'd4, 2'b01}) begin
            bad++; $display("FAIL wr_single_aw got=%h/%0d/%0d/%b want=1000/0/4/01", rec_addr, rec_len, rec_size, rec_burst);
        end
        total++;
        if (rec_n !== 1 || rec_last[0] !== 1'b1 || rec_data[0] !== wr_pat(0)) begin
            bad++; $display("FAIL wr_single_beat got n=%0d last=%b want n=1 last=1", rec_n, rec_last[0]);
        end
        total++;
        if (rec_done_resp !== 2'b11) begin bad++; $display("FAIL wr_single_resp got=%b want=11", rec_done_resp); end
        total++;
        if (rec_done_iter - rec_acc_iter !== 4) begin bad++; $display("FAIL wr_single_latency got=%0d want=4", rec_done_iter - rec_acc_iter); end
    endtask

    task automatic test_read_stall_slverr();
        for (int k = 0; k < 32; k++) rd_resp_tab[k] = 2'b00;
        rd_resp_tab[2] = 2'b10;
        run_read(64'h0000_0001_0000_0400, 8'd7, 8, 1'b1);
        total++;
        if (rec_timeout !== 1'b0) begin bad++; $display("FAIL rd_stall_timeout got=1 want=0"); end
        total++;
        if (rec_n !== 8 || rec_unstable !== 1'b0) begin bad++; $display("FAIL rd_stall_beats got=%0d unstable=%b want=8 unstable=0", rec_n, rec_unstable); end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (rec_data[k] !== rd_pat(k) || rec_resp[k] !== ((k == 2) ? 2'b10 : 2'b00)) begin
                bad++; $display("FAIL rd_stall_beat%0d got=%h resp=%b want=%h", k, rec_data[k], rec_resp[k], rd_pat(k));
            end
        end
        total++;
        if (rec_done_resp !== 2'b10) begin bad++; $display("FAIL rd_stall_resp got=%b want=10", rec_done_resp); end
    endtask

    task automatic test_read_resp_max();
        for (int k = 0; k < 32; k++) rd_resp_tab[k] = 2'b00;
        rd_resp_tab[0] = 2'b01; rd_resp_tab[1] = 2'b11;
        run_read(64'h800, 8'd2, 3, 1'b0);
        total++;
        if (rec_n !== 3 || rec_done_resp !== 2'b11) begin bad++; $display("FAIL rd_max_resp got n=%0d resp=%b want n=3 resp=11", rec_n, rec_done_resp); end
    endtask

    task automatic test_read_early_rlast();
        for (int k = 0; k < 32; k++) rd_resp_tab[k] = 2'b00;
        run_read(64'h900, 8'd3, 2, 1'b0);
        total++;
        if (rec_timeout !== 1'b0) begin bad++; $display("FAIL rd_early_timeout got=1 want=0"); end
        total++;
        if (rec_n !== 2 || rec_last[1] !== 1'b1) begin bad++; $display("FAIL rd_early_beats got=%0d last=%b want=2 last=1", rec_n, rec_last[1]); end
        total++;
        if (rec_done_resp !== 2'b10) begin bad++; $display("FAIL rd_early_resp got=%b want=10", rec_done_resp); end
    endtask

    task automatic test_write_long();
        run_write(64'h2000, 8'd15, 2'b01, 1'b1, -1);
        total++;
        if (rec_timeout !== 1'b0) begin bad++; $display("FAIL wr_long_timeout got=1 want=0"); end
        total++;
        if ({rec_addr, rec_len} !== {64'h2000, 8'd15} || rec_unstable !== 1'b0) begin
            bad++; $display("FAIL wr_long_aw got=%h/%0d unstable=%b want=2000/15 unstable=0", rec_addr, rec_len, rec_unstable);
        end
        total++;
        if (rec_n !== 16 || rec_last_cnt !== 1 || rec_last[15] !== 1'b1) begin
            bad++; $display("FAIL wr_long_last got n=%0d lastcnt=%0d last15=%b want 16/1/1", rec_n, rec_last_cnt, rec_last[15]);
        end
        for (int k = 0; k < 16; k++) begin
            total++;
            if (rec_data[k] !== wr_pat(k)) begin bad++; $display("FAIL wr_long_beat%0d got=%h want=%h", k, rec_data[k], wr_pat(k)); end
        end
        total++;
        if (rec_done_resp !== 2'b01) begin bad++; $display("FAIL wr_long_resp got=%b want=01", rec_done_resp); end
    endtask

    task automatic test_reset_mid();
        run_write(64'h3000, 8'd7, 2'b00, 1'b0, 4);
        total++;
        if (rec_n !== 4) begin bad++; $display("FAIL mid_abort_point got=%0d want=4", rec_n); end
        total++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rvalid_o, wready_o, done_valid_o} !== 8'h00) begin
            bad++; $display("FAIL mid_valids got=%b want=00000000",
                {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rvalid_o, wready_o, done_valid_o});
        end
        total++;
        if ({busy_o, cmd_ready_o, m_axi_awaddr} !== {2'b00, 64'h0}) begin
            bad++; $display("FAIL mid_state got busy=%b ready=%b awaddr=%h want 0/0/0", busy_o, cmd_ready_o, m_axi_awaddr);
        end
        @(posedge clk_i); #1;
        wvalid_i = 1'b0; m_axi_bvalid = 1'b0; cmd_valid_i = 1'b0;
        rst_i = 1'b0;
        for (int k = 0; k < 32; k++) rd_resp_tab[k] = 2'b00;
        run_read(64'h5000, 8'd1, 2, 1'b0);
        total++;
        if (rec_timeout !== 1'b0 || rec_n !== 2 || rec_done_resp !== 2'b00) begin
            bad++; $display("FAIL mid_after_read got n=%0d resp=%b timeout=%b want 2/00/0", rec_n, rec_done_resp, rec_timeout);
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_single();
        test_read_stall_slverr();
        test_read_resp_max();
        test_read_early_rlast();
        test_write_long();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
